// File: rtl/lfsr_prbs_gen.sv
// Parametrised PRBS generator: Fibonacci or Galois LFSR, OUT_WIDTH bits per
// cycle through a valid/ready output register, with seed, wrap and word tracking.
module lfsr_prbs_gen #(
  parameter int unsigned       DEGREE    = 7,
  parameter logic [DEGREE-1:0] FIB_TAPS  = 7'h41,
  parameter logic [DEGREE-1:0] GAL_TAPS  = 7'h03,
  parameter int unsigned       OUT_WIDTH = 1
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 Run_SI,
  input  logic                 SeedWr_SI,
  input  logic [DEGREE-1:0]    Seed_DI,
  input  logic                 Mode_SI,
  input  logic                 Ready_SI,
  output logic [OUT_WIDTH-1:0] Out_DO,
  output logic                 Valid_SO,
  output logic [DEGREE-1:0]    State_DO,
  output logic                 ZeroSeed_SO,
  output logic                 SeqWrap_SO,
  output logic [DEGREE-1:0]    WordCnt_DO
);

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } mode_e;

  localparam logic [DEGREE-1:0] ONE = DEGREE'(1);

  logic [DEGREE-1:0]    state_q, state_d;
  logic [DEGREE-1:0]    seed_q, seed_d;
  logic [DEGREE-1:0]    cnt_q, cnt_d;
  mode_e                mode_q, mode_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 zero_q, zero_d;
  logic                 wrap_q, wrap_d;

  logic [DEGREE-1:0]    step_state;
  logic [OUT_WIDTH-1:0] word;
  logic [DEGREE-1:0]    seed_eff;
  logic                 adv;

  // OUT_WIDTH chained single steps; each new bit enters at the top and is
  // shifted down, so after the last step bit 0 holds the oldest output bit.
  always_comb begin
    step_state = state_q;
    word       = '0;
    for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
      word = OUT_WIDTH'({step_state[DEGREE-1], word} >> 1);
      if (mode_q == MODE_GAL) begin
        step_state = {step_state[DEGREE-2:0], 1'b0} ^
                     (step_state[DEGREE-1] ? GAL_TAPS : '0);
      end else begin
        step_state = {step_state[DEGREE-2:0], ^(step_state & FIB_TAPS)};
      end
    end
  end

  assign seed_eff = (Seed_DI == '0) ? ONE : Seed_DI;
  assign adv      = Run_SI && (!valid_q || Ready_SI) && !SeedWr_SI;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    wrap_d  = 1'b0;
    if (SeedWr_SI) begin
      state_d = seed_eff;
      seed_d  = seed_eff;
      mode_d  = mode_e'(Mode_SI);
      valid_d = 1'b0;
      cnt_d   = '0;
      zero_d  = (Seed_DI == '0);
    end else if (adv) begin
      out_d   = word;
      valid_d = 1'b1;
      state_d = step_state;
      cnt_d   = cnt_q + ONE;
      wrap_d  = (step_state == seed_q);
    end else if (valid_q && Ready_SI) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ONE;
      seed_q  <= ONE;
      mode_q  <= MODE_FIB;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Out_DO      = out_q;
  assign Valid_SO    = valid_q;
  assign State_DO    = state_q;
  assign ZeroSeed_SO = zero_q;
  assign SeqWrap_SO  = wrap_q;
  assign WordCnt_DO  = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: one instance with OUT_WIDTH=1 and one
// with OUT_WIDTH=4 share stimulus; expected word streams are queued per seed.
module tb_lfsr_prbs_gen;

  logic       clk = 1'b0;
  logic       rst, run, seed_wr, mode, ready;
  logic [6:0] seed;

  logic [0:0] out0;
  logic       valid0, zero0, wrap0;
  logic [6:0] state0, cnt0;
  logic [3:0] out4;
  logic       valid4, zero4, wrap4;
  logic [6:0] state4, cnt4;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [6:0] word;
    logic [6:0] state;
    logic [6:0] cnt;
    logic       wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   prev_valid[2];
  bit   prev_ready;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  lfsr_prbs_gen #(.DEGREE(7), .FIB_TAPS(7'h41), .GAL_TAPS(7'h03), .OUT_WIDTH(1)) dut0 (
    .Clk_CI(clk), .Rst_RI(rst), .Run_SI(run), .SeedWr_SI(seed_wr), .Seed_DI(seed),
    .Mode_SI(mode), .Ready_SI(ready), .Out_DO(out0), .Valid_SO(valid0),
    .State_DO(state0), .ZeroSeed_SO(zero0), .SeqWrap_SO(wrap0), .WordCnt_DO(cnt0)
  );

  lfsr_prbs_gen #(.DEGREE(7), .FIB_TAPS(7'h41), .GAL_TAPS(7'h03), .OUT_WIDTH(4)) dut4 (
    .Clk_CI(clk), .Rst_RI(rst), .Run_SI(run), .SeedWr_SI(seed_wr), .Seed_DI(seed),
    .Mode_SI(mode), .Ready_SI(ready), .Out_DO(out4), .Valid_SO(valid4),
    .State_DO(state4), .ZeroSeed_SO(zero4), .SeqWrap_SO(wrap4), .WordCnt_DO(cnt4)
  );

  // Reference step for x^7 taps: Fibonacci feedback S[6]^S[0], Galois toggle 0x03.
  function automatic logic [6:0] next_state(input logic gal, input logic [6:0] s);
    logic [6:0] r;
    if (gal) begin
      r = s << 1;
      if (s[6]) r = r ^ 7'h03;
    end else begin
      r = (s << 1) | {6'b0, s[6] ^ s[0]};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [6:0] seed_in, input logic gal);
    logic [6:0] seed_e, s;
    exp_t       e;
    int         w;
    q0.delete();
    q1.delete();
    seed_e = (seed_in == 7'd0) ? 7'd1 : seed_in;
    for (int d = 0; d < 2; d++) begin
      w = (d == 0) ? 1 : 4;
      s = seed_e;
      for (int i = 0; i < 200; i++) begin
        e.word = '0;
        for (int k = 0; k < w; k++) begin
          e.word = e.word | (7'(s[6]) << k);
          s = next_state(gal, s);
        end
        e.state = s;
        e.cnt   = 7'((i + 1) % 128);
        e.wrap  = (s == seed_e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  task automatic mon_dut(input int d, input logic [6:0] o, input logic v,
                         input logic [6:0] st, input logic [6:0] ct, input logic wr);
    exp_t e;
    bit   fresh, empty;
    fresh = v && (!prev_valid[d] || prev_ready);
    if (fresh) begin
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        tests++;
        failed++;
        $display("FAIL d%0d_queue: got a word, expected none queued", d);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        cur[d] = e;
        chk($sformatf("d%0d_word", d),  32'(o),  32'(e.word));
        chk($sformatf("d%0d_state", d), 32'(st), 32'(e.state));
        chk($sformatf("d%0d_cnt", d),   32'(ct), 32'(e.cnt));
        chk($sformatf("d%0d_wrap", d),  32'(wr), 32'(e.wrap));
      end
    end else begin
      if (v) begin
        chk($sformatf("d%0d_hold_word", d),  32'(o),  32'(cur[d].word));
        chk($sformatf("d%0d_hold_state", d), 32'(st), 32'(cur[d].state));
        chk($sformatf("d%0d_hold_cnt", d),   32'(ct), 32'(cur[d].cnt));
      end
      chk($sformatf("d%0d_wrap_idle", d), 32'(wr), 32'd0);
    end
    prev_valid[d] = v;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_dut(0, {6'b0, out0}, valid0, state0, cnt0, wrap0);
      mon_dut(1, {3'b0, out4}, valid4, state4, cnt4, wrap4);
      prev_ready = ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [6:0] sv, input logic m);
    seed_wr = 1'b1;
    seed    = sv;
    mode    = m;
    tick();
    seed_wr = 1'b0;
    push_stream(sv, m);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out0"},   32'(out0),   32'd0);
    chk({tag, "_valid0"}, 32'(valid0), 32'd0);
    chk({tag, "_state0"}, 32'(state0), 32'h01);
    chk({tag, "_zero0"},  32'(zero0),  32'd0);
    chk({tag, "_wrap0"},  32'(wrap0),  32'd0);
    chk({tag, "_cnt0"},   32'(cnt0),   32'd0);
    chk({tag, "_out4"},   32'(out4),   32'd0);
    chk({tag, "_valid4"}, 32'(valid4), 32'd0);
    chk({tag, "_state4"}, 32'(state4), 32'h01);
    chk({tag, "_zero4"},  32'(zero4),  32'd0);
    chk({tag, "_cnt4"},   32'(cnt4),   32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; seed_wr = 1'b0; seed = 7'h00; mode = 1'b0; ready = 1'b1;
    prev_valid[0] = 1'b0;
    prev_valid[1] = 1'b0;
    prev_ready    = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    push_stream(7'h01, 1'b0);
    mon_en = 1'b1;

    // Fibonacci, seed 0x01
    load_seed(7'h01, 1'b0);
    chk("fib_load_state", 32'(state0), 32'h01);
    run = 1'b1;
    tick();
    chk("fib_w1_valid", 32'(valid0), 32'd1);
    chk("fib_w1_out",   32'(out0),   32'd0);
    chk("fib_w1_state", 32'(state0), 32'h03);
    chk("fib_w1_cnt",   32'(cnt0),   32'd1);
    tick();
    chk("fib_w2_out",   32'(out0),   32'd0);
    chk("fib_w2_state", 32'(state0), 32'h07);
    tick();
    chk("fib_w3_out",   32'(out0),   32'd0);
    chk("fib_w3_state", 32'(state0), 32'h0F);
    repeat (124) tick();
    chk("fib_wrap",     32'(wrap0), 32'd1);
    chk("fib_wrap_cnt", 32'(cnt0),  32'd127);

    // Backpressure, with a Mode_SI toggle that must be ignored
    ready = 1'b0;
    mode  = 1'b1;
    repeat (5) tick();
    ready = 1'b1;
    repeat (6) tick();

    // Galois, seed 0x40, loaded while a word is pending and Run is high
    load_seed(7'h40, 1'b1);
    chk("gal_load_valid", 32'(valid0), 32'd0);
    chk("gal_load_state", 32'(state0), 32'h40);
    tick();
    chk("gal_w1_out",   32'(out0),   32'd1);
    chk("gal_w1_state", 32'(state0), 32'h03);
    repeat (126) tick();
    chk("gal_wrap",     32'(wrap0), 32'd1);
    chk("gal_wrap_cnt", 32'(cnt0),  32'd127);

    // Zero-seed substitution and clearing
    run = 1'b0;
    tick();
    load_seed(7'h00, 1'b0);
    chk("zs_state", 32'(state0), 32'h01);
    chk("zs_flag0", 32'(zero0),  32'd1);
    chk("zs_flag4", 32'(zero4),  32'd1);
    load_seed(7'h55, 1'b0);
    chk("zs_clr_state", 32'(state0), 32'h55);
    chk("zs_clr_flag",  32'(zero0),  32'd0);

    // Seed load over a pending word with Run high and Ready low
    run   = 1'b1;
    ready = 1'b0;
    tick();
    chk("pend_valid", 32'(valid0), 32'd1);
    tick();
    load_seed(7'h2A, 1'b0);
    chk("pend_flush_valid0", 32'(valid0), 32'd0);
    chk("pend_flush_valid4", 32'(valid4), 32'd0);
    chk("pend_flush_cnt",    32'(cnt0),   32'd0);
    chk("pend_flush_state",  32'(state0), 32'h2A);
    tick();
    chk("pend_new_valid", 32'(valid0), 32'd1);
    chk("pend_new_cnt",   32'(cnt0),   32'd1);
    ready = 1'b1;
    tick();

    // OUT_WIDTH=4 against the serial stream (zero seed gives the 0x01 stream)
    load_seed(7'h00, 1'b0);
    chk("w4_zero", 32'(zero4), 32'd1);
    tick();
    chk("w4_w1_out",   32'(out4),   32'h0);
    chk("w4_w1_state", 32'(state4), 32'h1F);
    chk("w4_w1_cnt",   32'(cnt4),   32'd1);
    chk("w4_s1_state", 32'(state0), 32'h03);
    tick();
    chk("w4_w2_out",   32'(out4),   32'hC);
    chk("w4_w2_state", 32'(state4), 32'h7D);
    repeat (125) tick();
    chk("w4_wrap",     32'(wrap4), 32'd1);
    chk("w4_wrap_cnt", 32'(cnt4),  32'd127);
    chk("w1_wrap",     32'(wrap0), 32'd1);

    // Reset in mid-stream
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    run = 1'b0;
    push_stream(7'h01, 1'b0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
